// File: rtl/stage_fetch_prefetch.sv
// Fetch stage: issues sequential word requests to an in-order memory and queues {pc,instr} for decode.
// Head valid the cycle after the response; requests are throttled by in-flight count and queue credit.
module stage_fetch_prefetch #(
    parameter logic [31:0] RESET_PC    = 32'h0040_0000,
    parameter int          QUEUE_DEPTH = 4,
    parameter int          MAX_OUTST   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] pc_in,
    input  logic        stall,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_add4,
    output logic [31:0] pc_add8
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_q_pc  [QUEUE_DEPTH];
    logic [31:0]   r_q_ins [QUEUE_DEPTH];

    logic [31:0]   w_target;
    logic [OW-1:0] w_live;
    logic          w_credit_ok;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_drop_hit;

    assign w_target = pc_in & 32'hFFFF_FFFC;

    // Live requests (not already marked stale) each reserve a queue slot.
    assign w_live      = r_outst - r_drop;
    assign w_credit_ok = (int'(r_count) + int'(w_live)) < QUEUE_DEPTH;

    assign req_valid  = !reset && !load && (int'(r_outst) < MAX_OUTST) && w_credit_ok;
    assign req_addr   = r_fetch_pc;
    assign w_accept   = req_valid && req_ready;

    assign inst_valid = !reset && (r_count != '0);
    assign w_pop      = inst_valid && !stall && !load;
    assign w_drop_hit = resp_valid && (r_drop != '0);
    assign w_push     = !reset && !load && resp_valid && (r_drop == '0);

    assign instruction = r_q_ins[r_rd_ptr];
    assign pc          = r_q_pc[r_rd_ptr];
    assign pc_add4     = pc + 32'd4;
    assign pc_add8     = pc + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (load) begin
            // Everything still in flight after this cycle's response is stale.
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_outst    <= r_outst - OW'(resp_valid);
            r_drop     <= r_outst - OW'(resp_valid);
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
                r_wr_ptr  <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_drop_hit) begin
                r_drop <= r_drop - OW'(1);
            end
            r_outst <= r_outst + OW'(w_accept) - OW'(resp_valid);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]  <= r_resp_pc;
            r_q_ins[r_wr_ptr] <= resp_data;
        end
    end

    assert property (@(posedge clk) disable iff (reset) w_push |-> (r_count < CW'(QUEUE_DEPTH)));
    assert property (@(posedge clk) disable iff (reset) resp_valid |-> (r_outst != '0));

endmodule
